cpu_ctrl_seq: RTL and testbench
===============================

Name: cpu_ctrl_seq

Overview:
- Multi-cycle instruction sequencer sitting directly upstream of the calpart datapath (regfile + ALU).
- Fetches 16-bit instructions from an external synchronous program ROM and decodes them.
- Drives every datapath control (IE, ZE, OE, WE, WA, RAE, RAA, RBE, RBA, op, cal_value).
- Consumes the datapath zero flag Q for conditional jumps and handshakes the datapath's datain/dataout with the outside world.

Parameters:
- PC_W, 8, program counter / ROM address width; jump target = instr[PC_W-1:0] (PC_W <= 8).
- RSTACK_DEPTH, 4, return-stack depth (used only with CTRL_CALLRET_EN).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- pc  out  PC_W  ROM address; ROM returns instr one cycle later.
- instr  in  16  ROM data.
- q  in  1  datapath zero flag Q.
- in_valid  in  1  external input word present on datapath datain.
- in_ready  out  1  pulse: input word consumed this cycle.
- out_valid  out  1  pulse: datapath dataout valid this cycle.
- ie, ze, oe, we, rae, rbe  out  1 each  datapath controls.
- wa, raa, rba  out  2 each  register addresses.
- op  out  3  ALU opcode.
- cal_value  out  4  ALU immediate.
- halted  out  1  high in HALT.
- stack_err  out  1  sticky return-stack fault; tied 0 without CTRL_CALLRET_EN.

Behaviour:
- Instruction fields: opc=[15:12], rd=[11:10], ra=[9:8], rb=[7:6], imm=[7:4], aluop=[2:0], target=[PC_W-1:0]. Bit 3 reserved.
- Opcodes:
  - 0 NOP.
  - 1 IN: rd<=datain.
  - 2 OUT: compute A op B and present it on dataout.
  - 3 ALU: rd<=A op B; Z flag updated.
  - 4 JMP.
  - 5 JZ: taken if q=1.
  - 6 JNZ: taken if q=0.
  - 7 CALL, 8 RET: only with the optional feature.
  - F HALT.
  - Any other opcode: NOP.
- States: FETCH -> DECODE -> EXEC -> FETCH. IN waits in WAIT_IN. HALT is absorbing until reset.
- FETCH: pc stable; ROM read.
- DECODE: IR<=instr.
- EXEC: controls asserted for exactly one cycle; pc<=pc+1, or <=target when a jump is taken.
- CPI is 3, except IN, which takes 3 + wait cycles.
- Control outputs are combinational from state+IR and are all 0 outside EXEC/WAIT_IN.
- cal_value=imm and op=aluop whenever rae is asserted.
- Per-instruction controls:
  - ALU: rae=1, raa=ra, rbe=1, rba=rb, we=1, wa=rd, ze=1. Register write and Q update occur on the EXEC edge.
  - OUT: rae/rbe/op as ALU, oe=1, out_valid=1, we=0, ze=0.
  - IN (WAIT_IN): if in_valid, then ie=1, we=1, wa=rd, in_ready=1, pc<=pc+1, then FETCH. Otherwise all controls 0 and remain in WAIT_IN.
  - JZ/JNZ: sample q during EXEC. The previous ALU result is already reflected, because Q updated >=2 cycles earlier.
- PC wrap: pc=2^PC_W-1 increments to 0, with no flag.
- HALT: halted=1, pc frozen, all controls 0, in_ready=0.
- Reset (any state, including mid-WAIT_IN): state=FETCH, pc=0, IR=0, halted=0, stack_err=0, all control outputs 0 in that cycle. A pending in_valid is not consumed.

Optional Feature:
- Macro: CTRL_CALLRET_EN.
- Defined:
  - CALL pushes pc+1 (mod 2^PC_W) and jumps to target.
  - RET pops into pc.
  - Push when full, or pop when empty: stack_err<=1 (sticky) and enter HALT; the stack is unchanged.
  - Reset empties the stack.
- Undefined: opcodes 7/8 execute as NOP; stack_err is constant 0; no stack storage is generated.

Decomposition:
- Package cpu_ctrl_pkg: opcode localparams, state enum encoding, field bit positions, instruction width 16.
- Sub-module cpu_ctrl_rstack (LIFO, push/pop/full/empty, PC_W x RSTACK_DEPTH), instantiated only under CTRL_CALLRET_EN.

Test Plan:
- ALU timing: reset, then ROM[0]=ALU rd=1 ra=2 rb=3 aluop=5 -> we=1, wa=1, raa=2, rba=3, op=5, ze=1 for exactly one cycle in the 3rd cycle after reset release; pc=1 afterwards.
- IN handshake: IN rd=2 with in_valid low for 4 cycles, then high -> in_ready/ie/we pulse once on the first in_valid cycle; wa=2; no controls during the wait.
- Conditional jumps: JZ 0x40 with q=1 -> pc=0x40; same with q=0 -> pc=pc+1. JNZ covers the inverse.
- Wrap and halt: JMP 0xFF, ROM[0xFF]=NOP -> pc wraps to 0x00. HALT -> halted=1, pc and controls frozen for 20 cycles; reset clears.
- Reset mid-WAIT_IN: pulse reset while in_valid=0 -> pc=0, state FETCH, in_ready never asserted.
- CTRL_CALLRET_EN: 5 nested CALLs with depth 4 -> 5th sets stack_err=1 and halted=1. CALL/RET pair returns to call address+1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcodes, instruction field positions and sequencer states
package cpu_ctrl_pkg;

    localparam int INSTR_W = 16;

    // Instruction field bit positions
    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 12;
    localparam int RD_HI    = 11;
    localparam int RD_LO    = 10;
    localparam int RA_HI    = 9;
    localparam int RA_LO    = 8;
    localparam int RB_HI    = 7;
    localparam int RB_LO    = 6;
    localparam int IMM_HI   = 7;
    localparam int IMM_LO   = 4;
    localparam int ALUOP_HI = 2;
    localparam int ALUOP_LO = 0;

    // Opcodes; anything not listed executes as NOP
    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_IN   = 4'h1;
    localparam logic [3:0] OPC_OUT  = 4'h2;
    localparam logic [3:0] OPC_ALU  = 4'h3;
    localparam logic [3:0] OPC_JMP  = 4'h4;
    localparam logic [3:0] OPC_JZ   = 4'h5;
    localparam logic [3:0] OPC_JNZ  = 4'h6;
    localparam logic [3:0] OPC_CALL = 4'h7;
    localparam logic [3:0] OPC_RET  = 4'h8;
    localparam logic [3:0] OPC_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_WAIT_IN = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

endpackage

// File: rtl/cpu_ctrl_rstack.sv
// rtl/cpu_ctrl_rstack.sv - return-address LIFO; push when full / pop when empty are ignored
module cpu_ctrl_rstack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_top,
    output logic         o_full,
    output logic         o_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_top_idx;

    assign w_wr_idx  = IDX_W'(r_count);
    assign w_top_idx = IDX_W'(r_count - CNT_W'(1));
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_top     = r_mem[w_top_idx];

    // Stack storage and occupancy; reset only empties the stack
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_data;
            r_count         <= r_count + CNT_W'(1);
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// rtl/cpu_ctrl_seq.sv - multi-cycle fetch/decode/exec sequencer for the calpart datapath; CALL/RET under CTRL_CALLRET_EN
module cpu_ctrl_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W         = 8,
    parameter int RSTACK_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    output logic [PC_W-1:0]     pc,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                q,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    output logic                ie,
    output logic                ze,
    output logic                oe,
    output logic                we,
    output logic                rae,
    output logic                rbe,
    output logic [1:0]          wa,
    output logic [1:0]          raa,
    output logic [1:0]          rba,
    output logic [2:0]          op,
    output logic [3:0]          cal_value,
    output logic                halted,
    output logic                stack_err
);

    if (PC_W < 1 || PC_W > 8 || RSTACK_DEPTH < 1) begin : g_param_check
        $error("cpu_ctrl_seq: PC_W must be 1..8 and RSTACK_DEPTH >= 1");
    end

    state_t              r_state;
    state_t              w_next_state;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     w_next_pc;
    logic [PC_W-1:0]     w_pc_inc;
    logic [INSTR_W-1:0]  r_ir;
    logic [3:0]          w_opc;
    logic [PC_W-1:0]     w_target;
    logic                w_in_phase;

    assign w_opc      = r_ir[OPC_HI:OPC_LO];
    assign w_target   = r_ir[PC_W-1:0];
    assign w_pc_inc   = r_pc + PC_W'(1);
    assign pc         = r_pc;
    assign halted     = (r_state == ST_HALT);
    // IN handshakes in EXEC already, so zero wait cycles keeps CPI at 3
    assign w_in_phase = (r_state == ST_WAIT_IN) || (r_state == ST_EXEC && w_opc == OPC_IN);

`ifdef CTRL_CALLRET_EN
    logic            w_push;
    logic            w_pop;
    logic            w_err_set;
    logic            w_stk_full;
    logic            w_stk_empty;
    logic [PC_W-1:0] w_stk_top;
    logic            r_stack_err;

    cpu_ctrl_rstack #(
        .W     (PC_W),
        .DEPTH (RSTACK_DEPTH)
    ) u_rstack (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_stk_top),
        .o_full  (w_stk_full),
        .o_empty (w_stk_empty)
    );

    // Sticky stack fault flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stack_err <= 1'b0;
        end else if (w_err_set) begin
            r_stack_err <= 1'b1;
        end
    end

    assign stack_err = r_stack_err;
`else
    assign stack_err = 1'b0;
`endif

    // State, program counter and instruction register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (r_state == ST_DECODE) begin
                r_ir <= instr;
            end
        end
    end

    // Next state, next pc and datapath controls; everything forced idle while reset is high
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        ie           = 1'b0;
        ze           = 1'b0;
        oe           = 1'b0;
        we           = 1'b0;
        rae          = 1'b0;
        rbe          = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        wa           = '0;
        raa          = '0;
        rba          = '0;
        op           = '0;
        cal_value    = '0;
`ifdef CTRL_CALLRET_EN
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_err_set    = 1'b0;
`endif
        if (!reset) begin
            case (r_state)
                ST_FETCH:  w_next_state = ST_DECODE;
                ST_DECODE: w_next_state = ST_EXEC;
                ST_EXEC: begin
                    w_next_state = ST_FETCH;
                    w_next_pc    = w_pc_inc;
                    case (w_opc)
                        OPC_OUT: begin
                            rae       = 1'b1;
                            rbe       = 1'b1;
                            raa       = r_ir[RA_HI:RA_LO];
                            rba       = r_ir[RB_HI:RB_LO];
                            oe        = 1'b1;
                            out_valid = 1'b1;
                        end
                        OPC_ALU: begin
                            rae = 1'b1;
                            rbe = 1'b1;
                            raa = r_ir[RA_HI:RA_LO];
                            rba = r_ir[RB_HI:RB_LO];
                            we  = 1'b1;
                            wa  = r_ir[RD_HI:RD_LO];
                            ze  = 1'b1;
                        end
                        OPC_JMP: w_next_pc = w_target;
                        OPC_JZ:  if (q)  w_next_pc = w_target;
                        OPC_JNZ: if (!q) w_next_pc = w_target;
`ifdef CTRL_CALLRET_EN
                        OPC_CALL: begin
                            if (w_stk_full) begin
                                w_err_set    = 1'b1;
                                w_next_state = ST_HALT;
                                w_next_pc    = r_pc;
                            end else begin
                                w_push    = 1'b1;
                                w_next_pc = w_target;
                            end
                        end
                        OPC_RET: begin
                            if (w_stk_empty) begin
                                w_err_set    = 1'b1;
                                w_next_state = ST_HALT;
                                w_next_pc    = r_pc;
                            end else begin
                                w_pop     = 1'b1;
                                w_next_pc = w_stk_top;
                            end
                        end
`endif
                        OPC_HALT: begin
                            w_next_state = ST_HALT;
                            w_next_pc    = r_pc;
                        end
                        default: ;
                    endcase
                end
                ST_WAIT_IN, ST_HALT: ;
                default: w_next_state = ST_FETCH;
            endcase

            if (w_in_phase) begin
                w_next_state = ST_WAIT_IN;
                w_next_pc    = r_pc;
                if (in_valid) begin
                    ie           = 1'b1;
                    we           = 1'b1;
                    wa           = r_ir[RD_HI:RD_LO];
                    in_ready     = 1'b1;
                    w_next_pc    = w_pc_inc;
                    w_next_state = ST_FETCH;
                end
            end

            if (rae) begin
                op        = r_ir[ALUOP_HI:ALUOP_LO];
                cal_value = r_ir[IMM_HI:IMM_LO];
            end
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb/tb_cpu_ctrl_seq.sv - directed self-checking bench for cpu_ctrl_seq
module tb_cpu_ctrl_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        q = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready, out_valid, ie, ze, oe, we, rae, rbe;
    logic [1:0]  wa, raa, rba;
    logic [2:0]  op;
    logic [3:0]  cal_value;
    logic        halted, stack_err;

    logic [15:0] rom [0:255];
    int          total = 0;
    int          bad   = 0;

    localparam logic [7:0] C_IE  = 8'h80;
    localparam logic [7:0] C_ZE  = 8'h40;
    localparam logic [7:0] C_OE  = 8'h20;
    localparam logic [7:0] C_WE  = 8'h10;
    localparam logic [7:0] C_RAE = 8'h08;
    localparam logic [7:0] C_RBE = 8'h04;
    localparam logic [7:0] C_INR = 8'h02;
    localparam logic [7:0] C_OUT = 8'h01;

    logic [7:0] ctl;
    assign ctl = {ie, ze, oe, we, rae, rbe, in_ready, out_valid};

    cpu_ctrl_seq #(.PC_W(8), .RSTACK_DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .pc        (pc),
        .instr     (instr),
        .q         (q),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .ie        (ie),
        .ze        (ze),
        .oe        (oe),
        .we        (we),
        .rae       (rae),
        .rbe       (rbe),
        .wa        (wa),
        .raa       (raa),
        .rba       (rba),
        .op        (op),
        .cal_value (cal_value),
        .halted    (halted),
        .stack_err (stack_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) instr <= rom[pc];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_jump(input string tag, input logic [15:0] ins, input logic qv, input logic [7:0] exp_pc);
        clear_rom();
        rom[0] = ins;
        q = qv;
        do_reset();
        ticks(3);
        chk(tag, pc, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;

        // ALU timing: rd=1 ra=2 rb=3 imm=C aluop=5
        clear_rom();
        rom[0] = 16'h36C5;
        reset = 1'b1;
        tick();
        chk("rst_ctl", ctl, 0);
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_stack_err", stack_err, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("alu_fetch_ctl", ctl, 0);
        tick();
        chk("alu_decode_ctl", ctl, 0);
        tick();
        chk("alu_exec_ctl", ctl, C_WE | C_ZE | C_RAE | C_RBE);
        chk("alu_wa", wa, 1);
        chk("alu_raa", raa, 2);
        chk("alu_rba", rba, 3);
        chk("alu_op", op, 5);
        chk("alu_cal", cal_value, 4'hC);
        tick();
        chk("alu_after_ctl", ctl, 0);
        chk("alu_after_pc", pc, 1);

        // OUT: ra=1 rb=2 imm=9 aluop=6 -> 0x2000 | 0x0100 | 0x0080 | 0x0096
        clear_rom();
        rom[0] = 16'h2196;
        do_reset();
        ticks(2);
        chk("out_ctl", ctl, C_OE | C_RAE | C_RBE | C_OUT);
        chk("out_op", op, 6);
        chk("out_cal", cal_value, 4'h9);
        chk("out_raa", raa, 1);

        // IN rd=2 with four idle cycles before in_valid
        clear_rom();
        rom[0] = 16'h1800;
        in_valid = 1'b0;
        do_reset();
        ticks(2);
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            if (ctl !== 8'h00 || pc !== 8'h00) errs++;
            tick();
        end
        chk("in_wait_idle", errs, 0);
        in_valid = 1'b1;
        #1;
        chk("in_handshake_ctl", ctl, C_IE | C_WE | C_INR);
        chk("in_wa", wa, 2);
        tick();
        chk("in_after_pc", pc, 1);
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            if (in_ready !== 1'b0) errs++;
            tick();
        end
        chk("in_single_pulse", errs, 0);
        in_valid = 1'b0;

        // Conditional jumps
        run_jump("jz_taken",    16'h5040, 1'b1, 8'h40);
        run_jump("jz_nottaken", 16'h5040, 1'b0, 8'h01);
        run_jump("jnz_taken",   16'h6040, 1'b0, 8'h40);
        run_jump("jnz_nottaken",16'h6040, 1'b1, 8'h01);
        q = 1'b0;

        // PC wrap through NOP at 0xFF
        clear_rom();
        rom[0] = 16'h40FF;
        do_reset();
        ticks(3);
        chk("wrap_jmp_pc", pc, 8'hFF);
        ticks(3);
        chk("wrap_pc", pc, 8'h00);

        // HALT at address 1 holds for 20 cycles even with input offered
        clear_rom();
        rom[1] = 16'hF000;
        do_reset();
        ticks(6);
        chk("halt_halted", halted, 1);
        chk("halt_pc", pc, 1);
        in_valid = 1'b1;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (halted !== 1'b1 || pc !== 8'h01 || ctl !== 8'h00) errs++;
        end
        chk("halt_hold", errs, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("halt_rst_halted", halted, 0);
        chk("halt_rst_pc", pc, 0);
        reset = 1'b0;

        // Reset while parked in WAIT_IN
        clear_rom();
        rom[0] = 16'h1800;
        do_reset();
        ticks(5);
        reset = 1'b1;
        #1;
        chk("midin_rst_ctl", ctl, 0);
        tick();
        chk("midin_rst_pc", pc, 0);
        reset = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("midin_fetch_ctl", ctl, 0);
        tick();
        chk("midin_decode_ctl", ctl, 0);
        tick();
        chk("midin_exec_ctl", ctl, C_IE | C_WE | C_INR);
        in_valid = 1'b0;

`ifdef CTRL_CALLRET_EN
        // Five nested CALLs overflow a depth-4 stack
        clear_rom();
        rom[8'h00] = 16'h7010;
        rom[8'h10] = 16'h7020;
        rom[8'h20] = 16'h7030;
        rom[8'h30] = 16'h7040;
        rom[8'h40] = 16'h7050;
        do_reset();
        ticks(12);
        chk("call4_pc", pc, 8'h40);
        chk("call4_err", stack_err, 0);
        ticks(3);
        chk("call5_err", stack_err, 1);
        chk("call5_halted", halted, 1);
        chk("call5_pc", pc, 8'h40);

        // CALL/RET pair returns to call address + 1
        clear_rom();
        rom[8'h00] = 16'h7010;
        rom[8'h10] = 16'h8000;
        rom[8'h01] = 16'hF000;
        do_reset();
        chk("pair_rst_err", stack_err, 0);
        ticks(3);
        chk("pair_call_pc", pc, 8'h10);
        ticks(3);
        chk("pair_ret_pc", pc, 8'h01);
        chk("pair_err", stack_err, 0);

        // RET on empty stack
        clear_rom();
        rom[0] = 16'h8000;
        do_reset();
        ticks(4);
        chk("ret_empty_err", stack_err, 1);
        chk("ret_empty_halted", halted, 1);
`else
        run_jump("call_as_nop", 16'h7040, 1'b0, 8'h01);
        chk("call_nop_err", stack_err, 0);
        run_jump("ret_as_nop", 16'h8000, 1'b0, 8'h01);
        chk("ret_nop_halted", halted, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
